// File: rtl/lcd1602_dev_model.sv
// HD44780-style device responder for the LCD1602 rs/rw/en/db bus.
// Define LCD1602_NIBBLE_MODE_EN to honour DL=0 (4-bit transfers).
module lcd1602_dev_model #(
  parameter logic [31:0] BUSY_CMD_CYC = 32'd2000,
  parameter logic [31:0] BUSY_CLR_CYC = 32'd82000,
  parameter int          SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic       lcd_en,
  input  logic [7:0] lcd_db_in,
  output logic [7:0] lcd_db_out,
  output logic       lcd_db_oe,
  output logic       busy,
  output logic       disp_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic [6:0] ac,
  output logic [5:0] shift_ofs,
  output logic       err,
  input  logic [6:0] dbg_addr,
  output logic [7:0] dbg_data
);

  logic [10:0] sq [SYNC_STAGES];
  logic        s_rs, s_rw, s_en, en_q;
  logic [7:0]  s_db;
  logic        id, sh, dl, ram_sel;
  logic [31:0] busy_cnt;
  logic        fill_active, booted;
  logic [6:0]  fill_idx;
  logic        nib;
  logic [3:0]  hi_q, rd_lo;
  logic        rise, fall, nib_mode, dl_quick, last;
  logic        do_wr, do_rd, bad;
  logic [7:0]  cmd, ram_rd, rd_byte;

  logic [7:0] ddram [80];
  logic [7:0] cgram [64];

  function automatic logic dd_ok(input logic [6:0] a);
    return a[5:0] < 6'd40;
  endfunction

  function automatic logic [6:0] dd_idx(input logic [6:0] a);
    return a[6] ? 7'd40 + {1'b0, a[5:0]} : {1'b0, a[5:0]};
  endfunction

  function automatic logic [6:0] ac_step(input logic [6:0] a,
                                         input logic up,
                                         input logic cg);
    if (cg) return {1'b0, up ? a[5:0] + 6'd1 : a[5:0] - 6'd1};
    if (up) return a == 7'h27 ? 7'h40 : a == 7'h67 ? 7'h00 : a + 7'd1;
    return a == 7'h00 ? 7'h67 : a == 7'h40 ? 7'h27 : a - 7'd1;
  endfunction

  function automatic logic [5:0] ofs_step(input logic [5:0] o,
                                          input logic up);
    if (up) return o == 6'd39 ? 6'd0 : o + 6'd1;
    return o == 6'd0 ? 6'd39 : o - 6'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sq[i] <= '0;
    end else begin
      sq[0] <= {lcd_rs, lcd_rw, lcd_en, lcd_db_in};
      for (int i = 1; i < SYNC_STAGES; i++) sq[i] <= sq[i-1];
    end
  end

  assign {s_rs, s_rw, s_en, s_db} = sq[SYNC_STAGES-1];
  assign busy = (busy_cnt != 32'd0) | fill_active;

  always_comb begin
    rise     = s_en & ~en_q;
    fall     = ~s_en & en_q;
    nib_mode = ~dl;
    // a 4-bit function set with DL=1 takes effect on its first strobe
    dl_quick = nib_mode & ~nib & fall & ~s_rw & ~s_rs
             & (s_db[7:4] == 4'h3);
    last     = ~nib_mode | nib | dl_quick;
    cmd      = s_db;
    if (dl_quick) cmd = {s_db[7:4], 4'h0};
    else if (nib_mode) cmd = {hi_q, s_db[7:4]};
    do_wr    = fall & ~s_rw & last & ~busy;
    do_rd    = fall & s_rw & s_rs & last & ~busy;
    bad      = fall & (~s_rw | s_rs) & last & busy;
    ram_rd   = ram_sel ? cgram[ac[5:0]]
             : dd_ok(ac) ? ddram[dd_idx(ac)] : 8'h20;
    rd_byte  = s_rs ? ram_rd : {busy, ac};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q        <= 1'b0;
      lcd_db_out  <= 8'h00;
      lcd_db_oe   <= 1'b0;
      disp_on     <= 1'b0;
      cursor_on   <= 1'b0;
      blink_on    <= 1'b0;
      ac          <= 7'h00;
      shift_ofs   <= 6'd0;
      err         <= 1'b0;
      id          <= 1'b1;
      sh          <= 1'b0;
      dl          <= 1'b1;
      ram_sel     <= 1'b0;
      busy_cnt    <= 32'd0;
      fill_active <= 1'b0;
      booted      <= 1'b0;
      fill_idx    <= 7'd0;
      nib         <= 1'b0;
      hi_q        <= 4'h0;
      rd_lo       <= 4'h0;
    end else begin
      en_q <= s_en;
      if (busy_cnt != 32'd0) busy_cnt <= busy_cnt - 32'd1;
      if (!booted) begin
        booted      <= 1'b1;
        fill_active <= 1'b1;
        fill_idx    <= 7'd0;
      end else if (fill_active) begin
        fill_idx <= fill_idx + 7'd1;
        if (fill_idx == 7'd79) fill_active <= 1'b0;
      end
      if (rise & s_rw) begin
        lcd_db_oe <= 1'b1;
        if (!nib_mode) begin
          lcd_db_out <= rd_byte;
        end else if (!nib) begin
          lcd_db_out <= {rd_byte[7:4], 4'h0};
          rd_lo      <= rd_byte[3:0];
        end else begin
          lcd_db_out <= {rd_lo, 4'h0};
        end
      end
      if (fall) lcd_db_oe <= 1'b0;
      if (fall & nib_mode) begin
        nib <= dl_quick ? 1'b0 : ~nib;
        if (!nib) hi_q <= s_db[7:4];
      end
      if (bad) err <= 1'b1;
      if (do_rd) begin
        ac       <= ac_step(ac, id, ram_sel);
        busy_cnt <= BUSY_CMD_CYC;
      end
      if (do_wr & s_rs) begin
        ac       <= ac_step(ac, id, ram_sel);
        busy_cnt <= BUSY_CMD_CYC;
        if (sh & ~ram_sel) shift_ofs <= ofs_step(shift_ofs, id);
      end
      if (do_wr & ~s_rs) begin
        busy_cnt <= BUSY_CMD_CYC;
        priority case (1'b1)
          cmd[7]: begin
            ram_sel <= 1'b0;
            if (cmd[6:0] >= 7'h68) begin
              ac  <= 7'h00;
              err <= 1'b1;
            end else if (cmd[6:0] >= 7'h28 && cmd[6:0] < 7'h40) begin
              ac  <= 7'h40;
              err <= 1'b1;
            end else begin
              ac <= cmd[6:0];
            end
          end
          cmd[6]: begin
            ram_sel <= 1'b1;
            ac      <= {1'b0, cmd[5:0]};
          end
          cmd[5]: begin
`ifdef LCD1602_NIBBLE_MODE_EN
            dl <= cmd[4];
`else
            if (!cmd[4]) err <= 1'b1;
`endif
          end
          cmd[4]: begin
            if (cmd[3]) shift_ofs <= ofs_step(shift_ofs, cmd[2]);
            else ac <= ac_step(ac, cmd[2], 1'b0);
          end
          cmd[3]: {disp_on, cursor_on, blink_on} <= cmd[2:0];
          cmd[2]: begin
            id <= cmd[1];
            sh <= cmd[0];
          end
          cmd[1]: begin
            ac        <= 7'h00;
            shift_ofs <= 6'd0;
            busy_cnt  <= BUSY_CLR_CYC;
          end
          cmd[0]: begin
            ac          <= 7'h00;
            shift_ofs   <= 6'd0;
            id          <= 1'b1;
            ram_sel     <= 1'b0;
            busy_cnt    <= BUSY_CLR_CYC;
            fill_active <= 1'b1;
            fill_idx    <= 7'd0;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fill_active) ddram[fill_idx] <= 8'h20;
    else if (do_wr & s_rs & ~ram_sel & dd_ok(ac))
      ddram[dd_idx(ac)] <= cmd;
    if (do_wr & s_rs & ram_sel) cgram[ac[5:0]] <= cmd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dbg_data <= 8'h00;
    else dbg_data <= dd_ok(dbg_addr) ? ddram[dd_idx(dbg_addr)] : 8'h20;
  end

endmodule
